bsg_counter_set_down_en: RTL and testbench



---
 rtl/bsg_counter_set_down_en.sv | 71 +++++++
 tb/tb_bsg_counter_set_down_en.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_counter_set_down_en.sv
`default_nettype none
// ============================================================================
// Module   : bsg_counter_set_down_en
// Brief    : Loadable down-counter with enable, saturating or wrapping at zero,
//            and registered expire/underflow pulses.
// Revision : 1.0
// ============================================================================
module bsg_counter_set_down_en #(
    parameter int width_p    = 3,
    parameter int init_val_p = 0,
    parameter int saturate_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic               en_i,
    input  logic [width_p-1:0] val_i,
    output logic [width_p-1:0] count_o,
    output logic               zero_o,
    output logic               expire_o,
    output logic               underflow_o
);

    localparam logic [width_p-1:0] c_INIT_VAL = width_p'(init_val_p);
    localparam logic [width_p-1:0] c_ONE      = width_p'(1);

    logic [width_p-1:0] count_q, count_d;
    logic               expire_q, expire_d;
    logic               underflow_q, underflow_d;
    logic               w_is_zero, w_is_one;

    assign w_is_zero = (count_q == '0);
    assign w_is_one  = (count_q == c_ONE);

    always_comb begin
        count_d     = count_q;
        expire_d    = 1'b0;
        underflow_d = 1'b0;
        if (set_i) begin
            count_d = val_i;
        end else if (en_i) begin
            if (w_is_zero) begin
                // Decrement at zero: flag it, then either hold or wrap.
                underflow_d = 1'b1;
                count_d     = (saturate_p != 0) ? '0 : '1;
            end else begin
                count_d  = count_q - c_ONE;
                expire_d = w_is_one;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q     <= c_INIT_VAL;
            expire_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            expire_q    <= expire_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign zero_o      = w_is_zero;
    assign expire_o    = expire_q;
    assign underflow_o = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bsg_counter_set_down_en.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_counter_set_down_en
// Brief    : Self-checking bench; four counter configurations share stimulus.
// Revision : 1.0
// ============================================================================
module tb_bsg_counter_set_down_en;

    logic       clk = 1'b0;
    logic       r_reset = 1'b1;
    logic       r_set = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] r_val = 8'd0;

    always #5 clk = ~clk;

    // Configurations: {width, init, saturate}
    localparam int c_W[4]    = '{3, 3, 1, 8};
    localparam int c_INIT[4] = '{0, 0, 1, 200};
    localparam int c_SAT[4]  = '{1, 0, 0, 1};

    logic [2:0] w_c0, w_c1;
    logic [0:0] w_c2;
    logic [7:0] w_c3;
    logic [3:0] w_z, w_x, w_u;

    bsg_counter_set_down_en #(.width_p(3), .init_val_p(0), .saturate_p(1)) u_dut0 (
        .clk_i(clk), .reset_i(r_reset), .set_i(r_set), .en_i(r_en), .val_i(r_val[2:0]),
        .count_o(w_c0), .zero_o(w_z[0]), .expire_o(w_x[0]), .underflow_o(w_u[0]));
    bsg_counter_set_down_en #(.width_p(3), .init_val_p(0), .saturate_p(0)) u_dut1 (
        .clk_i(clk), .reset_i(r_reset), .set_i(r_set), .en_i(r_en), .val_i(r_val[2:0]),
        .count_o(w_c1), .zero_o(w_z[1]), .expire_o(w_x[1]), .underflow_o(w_u[1]));
    bsg_counter_set_down_en #(.width_p(1), .init_val_p(1), .saturate_p(0)) u_dut2 (
        .clk_i(clk), .reset_i(r_reset), .set_i(r_set), .en_i(r_en), .val_i(r_val[0:0]),
        .count_o(w_c2), .zero_o(w_z[2]), .expire_o(w_x[2]), .underflow_o(w_u[2]));
    bsg_counter_set_down_en #(.width_p(8), .init_val_p(200), .saturate_p(1)) u_dut3 (
        .clk_i(clk), .reset_i(r_reset), .set_i(r_set), .en_i(r_en), .val_i(r_val),
        .count_o(w_c3), .zero_o(w_z[3]), .expire_o(w_x[3]), .underflow_o(w_u[3]));

    logic [7:0] w_cnt [4];
    assign w_cnt[0] = {5'd0, w_c0};
    assign w_cnt[1] = {5'd0, w_c1};
    assign w_cnt[2] = {7'd0, w_c2};
    assign w_cnt[3] = w_c3;

    typedef struct {
        int         idx;
        logic [7:0] cnt;
        logic       z;
        logic       x;
        logic       u;
    } exp_t;

    typedef struct {
        bit         r;
        bit         s;
        bit         e;
        logic [7:0] v;
        logic [7:0] c;
        bit         z;
        bit         x;
        bit         u;
    } row_t;

    exp_t       sb_q[$];
    logic [7:0] m_cnt [4];
    int         n_pass = 0;
    int         n_total = 0;

    // Reference: returns {next_count, expire, underflow}
    function automatic logic [9:0] model_step(input int w, input int sat, input int init,
                                              input logic [7:0] cnt, input bit r, input bit s,
                                              input bit e, input logic [7:0] v);
        logic [7:0] mask;
        logic [7:0] nc;
        logic       ex;
        logic       un;
        mask = 8'((1 << w) - 1);
        nc   = cnt;
        ex   = 1'b0;
        un   = 1'b0;
        if (r) begin
            nc = 8'(init) & mask;
        end else if (s) begin
            nc = v & mask;
        end else if (e) begin
            if (cnt == 8'd0) begin
                un = 1'b1;
                nc = (sat != 0) ? 8'd0 : mask;
            end else begin
                ex = (cnt == 8'd1);
                nc = cnt - 8'd1;
            end
        end
        return {nc, ex, un};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(input bit r, input bit s, input bit e, input logic [7:0] v);
        logic [9:0] res;
        exp_t       ex;
        r_reset = r;
        r_set   = s;
        r_en    = e;
        r_val   = v;
        for (int k = 0; k < 4; k++) begin
            res      = model_step(c_W[k], c_SAT[k], c_INIT[k], m_cnt[k], r, s, e, v);
            m_cnt[k] = res[9:2];
            sb_q.push_back('{k, res[9:2], (res[9:2] == 8'd0), res[1], res[0]});
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            check($sformatf("model_dut%0d", ex.idx),
                  {20'd0, w_cnt[ex.idx], w_z[ex.idx], w_x[ex.idx], w_u[ex.idx], 1'b0},
                  {20'd0, ex.cnt, ex.z, ex.x, ex.u, 1'b0});
        end
    endtask

    row_t tbl[20];

    initial begin
        for (int k = 0; k < 4; k++) m_cnt[k] = 8'd0;

        // Directed vectors for width 3, init 0, saturating instance
        tbl[0]  = '{1, 0, 1, 8'd0, 8'd0, 1, 0, 0};
        tbl[1]  = '{1, 1, 1, 8'd5, 8'd0, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 8'd0, 8'd0, 1, 0, 1};
        tbl[3]  = '{0, 1, 0, 8'd3, 8'd3, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 8'd0, 8'd2, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 8'd0, 8'd1, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 8'd0, 8'd0, 1, 1, 0};
        tbl[7]  = '{0, 0, 1, 8'd0, 8'd0, 1, 0, 1};
        tbl[8]  = '{0, 0, 1, 8'd0, 8'd0, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 8'd0, 8'd0, 1, 0, 0};
        tbl[10] = '{0, 1, 0, 8'd1, 8'd1, 0, 0, 0};
        tbl[11] = '{0, 1, 1, 8'd5, 8'd5, 0, 0, 0};
        tbl[12] = '{0, 0, 1, 8'd0, 8'd4, 0, 0, 0};
        tbl[13] = '{1, 0, 1, 8'd0, 8'd0, 1, 0, 0};
        tbl[14] = '{0, 1, 0, 8'd0, 8'd0, 1, 0, 0};
        tbl[15] = '{0, 1, 0, 8'd7, 8'd7, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 8'd0, 8'd7, 0, 0, 0};
        tbl[17] = '{0, 1, 0, 8'd1, 8'd1, 0, 0, 0};
        tbl[18] = '{0, 0, 1, 8'd0, 8'd0, 1, 1, 0};
        tbl[19] = '{0, 1, 1, 8'd0, 8'd0, 1, 0, 0};

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].v);
            check($sformatf("tbl%0d_count", i), {24'd0, w_cnt[0]}, {24'd0, tbl[i].c});
            check($sformatf("tbl%0d_flags", i), {29'd0, w_z[0], w_x[0], w_u[0]},
                  {29'd0, tbl[i].z, tbl[i].x, tbl[i].u});
        end

        // Wrapping instance decrements through zero; width-1 instance expires
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b1, 8'd0);
        check("wrap_count", {29'd0, w_c1}, 32'd7);
        check("wrap_pulses", {30'd0, w_x[1], w_u[1]}, 32'd1);
        check("w1_expire", {30'd0, w_c2, w_x[2]}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 8'd0);
        check("wrap_next", {28'd0, w_c1, w_u[1]}, {28'd0, 3'd6, 1'b0});
        check("w1_underflow", {30'd0, w_c2, w_u[2]}, 32'd3);

        // Random traffic against the reference model
        for (int n = 0; n < 10000; n++) begin
            logic [7:0] v;
            v = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 65, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
